// File: rtl/irq_requester.sv
// ---------------------------------------------------------------------------
// irq_requester
//
// Collects rising-edge events from up to eight peripheral lines, masks and
// prioritises them, and raises a registered interrupt request towards the
// CPU interrupt controller.
//
// The request is held until the core is observed fetching from the
// interrupt vector (ISR entry). The block then waits for the return-from-
// interrupt PC mux select before re-arming. A request that sees no ISR entry
// within the timeout window is withdrawn and re-issued.
//
// Ports
//   instr_clock     in   1            single clock, rising edge
//   reset_n         in   1            asynchronous, active-low reset
//   src_event       in   NUM_SOURCES  peripheral event lines (rising edge = event)
//   mask            in   NUM_SOURCES  1 enables the matching source
//   pc_out          in   11           PC from the interrupt controller
//   pc_mux_control  in   2            PC mux select from the decoder
//   overrun_clear   in   1            one-cycle pulse, clears all overrun bits
//   irq             out  1            registered interrupt request
//   cause           out  CAUSE_W      index of the requested / serviced source
//   in_service      out  1            high while the ISR runs
//   pending         out  NUM_SOURCES  latched, not-yet-serviced events
//   overrun         out  NUM_SOURCES  sticky: event seen on an already pending source
//   retry           out  1            one-cycle pulse on request timeout
//
// Handshake: irq rises when a request is issued and stays high until ISR
// entry (pc_out == INTERRUPT_VECTOR) is sampled or the timeout expires.
// in_service then stays high until rfi (pc_mux_control == PC_SAVE) is
// sampled. At most one request is outstanding; IDLE lasts at least one
// cycle between requests.
// ---------------------------------------------------------------------------
module irq_requester #(
    parameter int          NUM_SOURCES      = 4,
    parameter int          CAUSE_W          = $clog2(NUM_SOURCES),
    parameter logic [10:0] INTERRUPT_VECTOR = 11'h4,
    parameter logic [1:0]  PC_SAVE          = 2'h3,
    parameter logic [7:0]  ACK_TIMEOUT      = 8'd255
) (
    input  logic                   instr_clock,
    input  logic                   reset_n,
    input  logic [NUM_SOURCES-1:0] src_event,
    input  logic [NUM_SOURCES-1:0] mask,
    input  logic [10:0]            pc_out,
    input  logic [1:0]             pc_mux_control,
    input  logic                   overrun_clear,
    output logic                   irq,
    output logic [CAUSE_W-1:0]     cause,
    output logic                   in_service,
    output logic [NUM_SOURCES-1:0] pending,
    output logic [NUM_SOURCES-1:0] overrun,
    output logic                   retry
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                 state_q,      state_d;
    logic [NUM_SOURCES-1:0] prev_q;
    logic [NUM_SOURCES-1:0] pending_q,    pending_d;
    logic [NUM_SOURCES-1:0] overrun_q,    overrun_d;
    logic                   irq_q,        irq_d;
    logic                   in_service_q, in_service_d;
    logic                   retry_q,      retry_d;
    logic [CAUSE_W-1:0]     cause_q,      cause_d;
    logic [7:0]             cnt_q,        cnt_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NUM_SOURCES-1:0] evt;
    logic [NUM_SOURCES-1:0] eligible;
    logic [NUM_SOURCES-1:0] cause_oh;
    logic [CAUSE_W-1:0]     winner;
    logic                   any_eligible;
    logic                   isr_entry;
    logic                   rfi_seen;

    assign evt          = src_event & ~prev_q;
    assign eligible     = pending_q & mask;
    assign any_eligible = |eligible;
    assign cause_oh     = NUM_SOURCES'(1) << cause_q;
    assign isr_entry    = (pc_out == INTERRUPT_VECTOR);
    assign rfi_seen     = (pc_mux_control == PC_SAVE);

    // Lowest eligible index wins: scan downwards so the last hit is the
    // smallest index.
    always_comb begin
        winner = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = CAUSE_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state, outputs, pending/overrun bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        in_service_d = in_service_q;
        retry_d      = 1'b0;
        cause_d      = cause_q;
        cnt_d        = cnt_q;

        // A new event always latches; a repeat event while still pending
        // flags an overrun.
        pending_d = pending_q | evt;
        overrun_d = (overrun_clear ? '0 : overrun_q) | (evt & pending_q);

        case (state_q)
            ST_IDLE: begin
                if (any_eligible) begin
                    state_d = ST_REQUEST;
                    irq_d   = 1'b1;
                    cause_d = winner;
                    cnt_d   = 8'd0;
                end
            end

            ST_REQUEST: begin
                if (isr_entry) begin
                    state_d      = ST_SERVICE;
                    irq_d        = 1'b0;
                    in_service_d = 1'b1;
                    // The serviced event is consumed. A fresh event on the
                    // same source at this edge is a new request, not an
                    // overrun, so it re-arms pending without flagging.
                    if (evt & cause_oh) begin
                        pending_d = pending_d | cause_oh;
                    end else begin
                        pending_d = pending_d & ~cause_oh;
                    end
                    overrun_d = (overrun_clear ? '0 : overrun_q)
                              | (evt & pending_q & ~cause_oh);
                end else if (cnt_q == ACK_TIMEOUT) begin
                    // Withdraw the request; pending is kept so the same
                    // source is re-issued from IDLE.
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                    retry_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_SERVICE: begin
                if (rfi_seen) begin
                    state_d      = ST_IDLE;
                    in_service_d = 1'b0;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                irq_d        = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge instr_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            prev_q       <= '0;
            pending_q    <= '0;
            overrun_q    <= '0;
            irq_q        <= 1'b0;
            in_service_q <= 1'b0;
            retry_q      <= 1'b0;
            cause_q      <= '0;
            cnt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            prev_q       <= src_event;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            irq_q        <= irq_d;
            in_service_q <= in_service_d;
            retry_q      <= retry_d;
            cause_q      <= cause_d;
            cnt_q        <= cnt_d;
        end
    end

    assign irq        = irq_q;
    assign cause      = cause_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;
    assign retry      = retry_q;

endmodule

// File: tb/tb_irq_requester.sv
// ---------------------------------------------------------------------------
// tb_irq_requester
//
// Directed scenarios followed by a randomized run. Every clock edge is
// mirrored by a behavioural model (sets of pending events, a phase, and a
// count of cycles spent requesting); all outputs are compared against it
// after each edge, and key points are also compared against fixed values.
// ---------------------------------------------------------------------------
module tb_irq_requester;

    localparam int          N    = 4;
    localparam int          CW   = 2;
    localparam logic [10:0] VEC  = 11'h4;
    localparam logic [1:0]  SAVE = 2'h3;
    localparam int          TO   = 3;

    // clock / reset
    logic instr_clock = 1'b0;
    logic reset_n     = 1'b0;
    always #5 instr_clock = ~instr_clock;

    // DUT signals
    logic [N-1:0]  src_event      = '0;
    logic [N-1:0]  mask           = '0;
    logic [10:0]   pc_out         = '0;
    logic [1:0]    pc_mux_control = '0;
    logic          overrun_clear  = 1'b0;
    logic          irq;
    logic [CW-1:0] cause;
    logic          in_service;
    logic [N-1:0]  pending;
    logic [N-1:0]  overrun;
    logic          retry;

    irq_requester #(
        .NUM_SOURCES     (N),
        .CAUSE_W         (CW),
        .INTERRUPT_VECTOR(VEC),
        .PC_SAVE         (SAVE),
        .ACK_TIMEOUT     (8'(TO))
    ) dut (
        .instr_clock   (instr_clock),
        .reset_n       (reset_n),
        .src_event     (src_event),
        .mask          (mask),
        .pc_out        (pc_out),
        .pc_mux_control(pc_mux_control),
        .overrun_clear (overrun_clear),
        .irq           (irq),
        .cause         (cause),
        .in_service    (in_service),
        .pending       (pending),
        .overrun       (overrun),
        .retry         (retry)
    );

    // scoreboard counters
    int tests_run = 0;
    int tests_failed = 0;

    // behavioural model
    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_SVC  = 2;

    int           m_phase;
    int           m_req_cycles;
    int           m_cause;
    bit           m_irq;
    bit           m_insvc;
    bit           m_retry;
    bit [N-1:0]   m_pend;
    bit [N-1:0]   m_ovr;
    bit [N-1:0]   m_prev;

    task automatic model_reset();
        m_phase      = PH_IDLE;
        m_req_cycles = 0;
        m_cause      = 0;
        m_irq        = 0;
        m_insvc      = 0;
        m_retry      = 0;
        m_pend       = '0;
        m_ovr        = '0;
        m_prev       = '0;
    endtask

    // Predicts the state after the coming edge from the current inputs.
    task automatic model_edge();
        bit [N-1:0] rise;
        bit [N-1:0] old_pend;
        bit         acked;
        int         first;
        rise     = src_event & ~m_prev;
        old_pend = m_pend;
        acked    = (m_phase == PH_REQ) && (pc_out == VEC);
        m_retry  = 0;

        if (overrun_clear) m_ovr = '0;
        for (int i = 0; i < N; i++) begin
            if (rise[i]) begin
                if (old_pend[i] && !(acked && i == m_cause)) m_ovr[i] = 1;
                m_pend[i] = 1;
            end
        end

        if (m_phase == PH_IDLE) begin
            first = -1;
            for (int i = N - 1; i >= 0; i--)
                if (old_pend[i] && mask[i]) first = i;
            if (first >= 0) begin
                m_phase      = PH_REQ;
                m_irq        = 1;
                m_cause      = first;
                m_req_cycles = 0;
            end
        end else if (m_phase == PH_REQ) begin
            m_req_cycles++;
            if (acked) begin
                m_phase = PH_SVC;
                m_irq   = 0;
                m_insvc = 1;
                m_pend[m_cause] = rise[m_cause];
            end else if (m_req_cycles == TO + 1) begin
                m_phase = PH_IDLE;
                m_irq   = 0;
                m_retry = 1;
            end
        end else begin
            if (pc_mux_control == SAVE) begin
                m_phase = PH_IDLE;
                m_insvc = 0;
            end
        end
        m_prev = src_event;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("m_irq",     32'(irq),        32'(m_irq));
        check("m_cause",   32'(cause),      32'(m_cause));
        check("m_insvc",   32'(in_service), 32'(m_insvc));
        check("m_pending", 32'(pending),    32'(m_pend));
        check("m_overrun", 32'(overrun),    32'(m_ovr));
        check("m_retry",   32'(retry),      32'(m_retry));
    endtask

    // One clock edge: predict, clock, sample 1 time unit after the edge.
    task automatic step();
        model_edge();
        @(posedge instr_clock);
        #1;
        check_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_irq"},     32'(irq),        32'd0);
        check({tag, "_cause"},   32'(cause),      32'd0);
        check({tag, "_insvc"},   32'(in_service), 32'd0);
        check({tag, "_pending"}, 32'(pending),    32'd0);
        check({tag, "_overrun"}, 32'(overrun),    32'd0);
        check({tag, "_retry"},   32'(retry),      32'd0);
    endtask

    task automatic ack_and_return();
        pc_out = VEC;
        step();
        check("ack_insvc", 32'(in_service), 32'd1);
        pc_out         = 11'h0;
        pc_mux_control = SAVE;
        step();
        check("rfi_insvc", 32'(in_service), 32'd0);
        pc_mux_control = 2'h0;
    endtask

    initial begin
        model_reset();
        // reset
        repeat (2) @(posedge instr_clock);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // 1: single event
        mask      = 4'b1111;
        src_event = 4'b0100;
        step();
        check("t1_pending", 32'(pending), 32'h4);
        check("t1_irq_early", 32'(irq), 32'd0);
        step();
        check("t1_irq",   32'(irq),   32'd1);
        check("t1_cause", 32'(cause), 32'd2);
        src_event = 4'b0000;
        pc_out    = VEC;
        step();
        check("t1_irq_ack", 32'(irq),        32'd0);
        check("t1_insvc",   32'(in_service), 32'd1);
        check("t1_pend0",   32'(pending),    32'd0);
        pc_out         = 11'h0;
        pc_mux_control = SAVE;
        step();
        check("t1_rfi", 32'(in_service), 32'd0);
        pc_mux_control = 2'h0;

        // 2: priority
        src_event = 4'b1010;
        step();
        check("t2_pending", 32'(pending), 32'ha);
        src_event = 4'b0000;
        step();
        check("t2_cause1", 32'(cause), 32'd1);
        check("t2_irq1",   32'(irq),   32'd1);
        ack_and_return();
        check("t2_idle_gap", 32'(irq), 32'd0);
        step();
        check("t2_cause3", 32'(cause), 32'd3);
        check("t2_irq3",   32'(irq),   32'd1);
        ack_and_return();

        // 3: mask
        mask      = 4'b0000;
        src_event = 4'b0001;
        step();
        check("t3_pending", 32'(pending), 32'h1);
        src_event = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t3_masked_irq", 32'(irq), 32'd0);
        end
        mask = 4'b0001;
        step();
        check("t3_irq",   32'(irq),   32'd1);
        check("t3_cause", 32'(cause), 32'd0);
        ack_and_return();

        // 4: overrun
        mask      = 4'b0000;
        src_event = 4'b0010;
        step();
        src_event = 4'b0000;
        step();
        src_event = 4'b0010;
        step();
        check("t4_overrun", 32'(overrun), 32'h2);
        check("t4_pending", 32'(pending), 32'h2);
        src_event     = 4'b0000;
        overrun_clear = 1'b1;
        step();
        overrun_clear = 1'b0;
        check("t4_ovr_clr",  32'(overrun), 32'h0);
        check("t4_pend_keep", 32'(pending), 32'h2);

        // 5: timeout (pc_out held away from the vector)
        mask = 4'b1111;
        step();
        check("t5_irq_c1", 32'(irq), 32'd1);
        for (int i = 0; i < TO; i++) begin
            step();
            check("t5_irq_held", 32'(irq), 32'd1);
        end
        step();
        check("t5_irq_drop", 32'(irq),   32'd0);
        check("t5_retry",    32'(retry), 32'd1);
        step();
        check("t5_irq_again", 32'(irq),   32'd1);
        check("t5_cause",     32'(cause), 32'd1);
        check("t5_retry_end", 32'(retry), 32'd0);
        ack_and_return();

        // 6: reset during SERVICE, source held high across release
        src_event = 4'b0001;
        step();
        step();
        check("t6_req", 32'(irq), 32'd1);
        pc_out = VEC;
        step();
        check("t6_svc", 32'(in_service), 32'd1);
        pc_out = 11'h0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("t6_async");
        repeat (2) @(posedge instr_clock);
        #1;
        reset_n = 1'b1;
        step();
        check("t6_pend_rel", 32'(pending), 32'h1);
        check("t6_irq_rel1", 32'(irq),     32'd0);
        step();
        check("t6_irq_rel2", 32'(irq),   32'd1);
        check("t6_cause",    32'(cause), 32'd0);
        ack_and_return();

        // randomized run against the model
        for (int n = 0; n < 600; n++) begin
            src_event      = N'($urandom);
            mask           = N'($urandom);
            pc_out         = ($urandom_range(0, 3) == 0) ? VEC : 11'($urandom_range(0, 15));
            pc_mux_control = 2'($urandom_range(0, 3));
            overrun_clear  = ($urandom_range(0, 7) == 0);
            step();
            if (n == 300) begin
                #2;
                reset_n = 1'b0;
                #1;
                model_reset();
                check_all_zero("rand_reset");
                @(posedge instr_clock);
                #1;
                reset_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
